sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_pkg.sv | 33 +++
 rtl/sdram_responder_mem.sv | 33 +++
 rtl/sdram_responder.sv | 143 ++++++++++++++
 tb/tb_sdram_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: command codes, FSM states and address-field widths shared by the responder
package sdram_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 11;
    localparam int COL_W  = 8;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;

    typedef enum logic [2:0] {
        CMD_LOAD_MODE = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVATE  = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_NOP       = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ACK,
        S_WRITE_BURST,
        S_READ_WAIT,
        S_READ_BURST,
        S_REFRESH_WAIT
    } state_e;

    function automatic logic is_rw(input cmd_e c);
        return c == CMD_READ || c == CMD_WRITE;
    endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// sdram_responder_mem: 32-bit byte-enabled storage, one write port and one registered read port
module sdram_responder_mem #(
    parameter int AddrWidth = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [3:0]           i_be,
    input  logic [AddrWidth-1:0] i_waddr,
    input  logic [31:0]          i_wdata,
    input  logic                 i_re,
    input  logic [AddrWidth-1:0] i_raddr,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [0:(1<<AddrWidth)-1];
    logic [31:0] r_rdata;

    // byte-lane writes; the array has no reset so contents survive rst
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (i_we && i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end

    // registered read; the output holds its value between reads
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDRAM-controller-side responder with init, bursts, refresh and misuse flag
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int InitCycles         = 16,
    parameter int CasLatency         = 3,
    parameter int RefreshCycles      = 8,
    parameter int MemAddressBitWidth = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        protocol_error
);

    localparam int IW = $clog2(InitCycles + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(InitCycles - 1);
    // read address goes out CasLatency-1 cycles after ack; the memory register adds the last cycle
    localparam logic [7:0] READ_WAIT_LAST = 8'(CasLatency - 3);
    localparam logic [7:0] REFRESH_LAST = 8'(RefreshCycles - 1);

    state_e                  r_state, w_next;
    logic [IW-1:0]           r_init_cnt;
    logic                    r_init_done;
    cmd_e                    r_cmd;
    logic [BANK_W-1:0]       r_bank, r_open_bank;
    logic [ROW_W-1:0]        r_row, r_open_row;
    logic [COL_W-1:0]        r_col;
    logic [7:0]              r_len, r_cnt;
    logic                    r_pc, r_row_open, r_err;
    logic                    w_accept, w_misuse, w_rw_bad, w_burst_done, w_we, w_re;
    logic [ADDR_W-1:0]       w_full;
    logic [MemAddressBitWidth-1:0] w_maddr;
    logic                    w_unused;

    assign w_accept = I_sdrc_cmd_en && r_state == S_IDLE && r_init_done;
    assign w_misuse = I_sdrc_cmd_en && !w_accept;
    assign w_rw_bad = w_accept && is_rw(cmd_e'(I_sdrc_cmd)) &&
                      (!r_row_open || I_sdrc_addr[ADDR_W-1 -: BANK_W] != r_open_bank);
    assign w_burst_done = (r_state == S_WRITE_BURST || r_state == S_READ_BURST) && r_cnt == r_len;
    // bursts use the row latched by the last ACTIVATE, even when misused
    assign w_full = {r_bank, r_open_row, r_col};
    assign w_maddr = w_full[MemAddressBitWidth-1:0];
    assign w_unused = &{1'b0, I_sdram_power_down, I_sdram_selfrefresh, w_full};
    assign O_sdrc_init_done = r_init_done;
    assign protocol_error = r_err;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:         w_next = r_init_cnt == INIT_LAST ? S_IDLE : S_INIT;
            S_IDLE:         w_next = w_accept ? S_ACK : S_IDLE;
            S_ACK:          w_next = r_cmd == CMD_WRITE   ? S_WRITE_BURST :
                                     r_cmd == CMD_READ    ? S_READ_WAIT :
                                     r_cmd == CMD_REFRESH ? S_REFRESH_WAIT : S_IDLE;
            S_WRITE_BURST:  w_next = w_burst_done ? S_IDLE : S_WRITE_BURST;
            S_READ_WAIT:    w_next = r_cnt == READ_WAIT_LAST ? S_READ_BURST : S_READ_WAIT;
            S_READ_BURST:   w_next = w_burst_done ? S_IDLE : S_READ_BURST;
            S_REFRESH_WAIT: w_next = r_cnt == REFRESH_LAST ? S_IDLE : S_REFRESH_WAIT;
            default:        w_next = S_INIT;
        endcase
    end

    // outputs; rst gates the strobes so an aborted burst stops writing immediately
    always_comb begin
        O_sdrc_cmd_ack = r_state == S_ACK;
        w_we = r_state == S_WRITE_BURST && !rst;
        w_re = r_state == S_READ_BURST && !rst;
    end

    // init counter, command latch, burst counters, open-row tracking and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_cmd       <= CMD_NOP;
            r_bank      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_len       <= '0;
            r_pc        <= 1'b0;
            r_cnt       <= '0;
            r_row_open  <= 1'b0;
            r_open_bank <= '0;
            r_open_row  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
            if (r_state == S_INIT && w_next == S_IDLE) r_init_done <= 1'b1;
            if (w_misuse || w_rw_bad) r_err <= 1'b1;
            r_cnt <= r_state != w_next ? 8'd0 : r_cnt + 8'd1;
            if (w_accept) begin
                r_cmd  <= cmd_e'(I_sdrc_cmd);
                r_bank <= I_sdrc_addr[ADDR_W-1 -: BANK_W];
                r_row  <= I_sdrc_addr[COL_W +: ROW_W];
                r_col  <= I_sdrc_addr[COL_W-1:0];
                r_len  <= I_sdrc_data_len;
                r_pc   <= I_sdrc_precharge_ctrl;
            end
            if (r_state == S_WRITE_BURST || r_state == S_READ_BURST) r_col <= r_col + 1'b1;
            if (r_state == S_ACK && r_cmd == CMD_ACTIVATE) begin
                r_row_open  <= 1'b1;
                r_open_bank <= r_bank;
                r_open_row  <= r_row;
            end
            if (r_state == S_ACK && (r_cmd == CMD_PRECHARGE || r_cmd == CMD_REFRESH)) r_row_open <= 1'b0;
            if (w_burst_done && r_pc) r_row_open <= 1'b0;
        end
    end

    sdram_responder_mem #(
        .AddrWidth(MemAddressBitWidth)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we),
        .i_be   (~I_sdrc_dqm),
        .i_waddr(w_maddr),
        .i_wdata(I_sdrc_data),
        .i_re   (w_re),
        .i_raddr(w_maddr),
        .o_rdata(O_sdrc_data)
    );

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: table vectors, directed corner sequences and random traffic against a word-array model
module tb_sdram_responder;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

    logic        clk = 0, rst = 1, cmd_en = 0, pc = 0, pd = 0, sr = 0;
    logic [2:0]  cmd = 3'b111;
    logic [20:0] addr = '0;
    logic [3:0]  dqm = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  len = '0;
    logic [31:0] rdata;
    logic        init_done, ack, perr;

    int n_tests = 0, n_fail = 0;

    logic [31:0] m_mem [4096];
    bit   [3:0]  m_vb  [4096];
    bit          m_open, m_err, m_known;
    logic [1:0]  m_bank;
    logic [10:0] m_row;
    logic [31:0] wbuf [256];
    logic [3:0]  mbuf [256];

    typedef struct {
        logic [7:0]  col;
        logic [31:0] prev;
        logic [31:0] data;
        logic [3:0]  dqm;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [6];

    sdram_responder dut (
        .clk                  (clk),
        .rst                  (rst),
        .I_sdrc_cmd_en        (cmd_en),
        .I_sdrc_cmd           (cmd),
        .I_sdrc_precharge_ctrl(pc),
        .I_sdram_power_down   (pd),
        .I_sdram_selfrefresh  (sr),
        .I_sdrc_addr          (addr),
        .I_sdrc_dqm           (dqm),
        .I_sdrc_data          (wdata),
        .I_sdrc_data_len      (len),
        .O_sdrc_data          (rdata),
        .O_sdrc_init_done     (init_done),
        .O_sdrc_cmd_ack       (ack),
        .protocol_error       (perr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // storage index: {bank,row,col} reduced to the 4096-word depth
    function automatic int idx(input logic [1:0] b, input logic [10:0] r, input logic [7:0] c);
        return int'({b, r, c}) % 4096;
    endfunction

    task automatic check_reset_vals;
        check("rst_init_done", init_done, 0);
        check("rst_ack", ack, 0);
        check("rst_data", rdata, 0);
        check("rst_err", perr, 0);
    endtask

    task automatic wait_init;
        int n = 0;
        while (!init_done && n < 40) begin
            tick;
            n++;
        end
        check("init_cycles", n, 16);
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        tick;
        check_reset_vals();
        rst = 0;
        m_open = 0;
        m_err = 0;
        m_known = 0;
        wait_init();
    endtask

    // issues a command from IDLE; returns #1 into the ack cycle
    task automatic do_cmd(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l, input bit p);
        cmd = c;
        addr = a;
        len = l;
        pc = p;
        cmd_en = 1;
        tick;
        cmd_en = 0;
        check("ack", ack, 1);
        if ((c == C_RD || c == C_WR) && (!m_open || a[20:19] != m_bank)) m_err = 1;
        if (c == C_ACT) begin
            m_open = 1;
            m_bank = a[20:19];
            m_row = a[18:8];
            m_known = 1;
        end
        if (c == C_PRE || c == C_REF || ((c == C_RD || c == C_WR) && p)) m_open = 0;
    endtask

    task automatic simple(input logic [2:0] c, input logic [20:0] a);
        do_cmd(c, a, 0, 0);
        tick;
        check("ack_pulse", ack, 0);
    endtask

    task automatic refresh;
        do_cmd(C_REF, '0, 0, 0);
        repeat (9) tick;
    endtask

    task automatic write_burst(input logic [20:0] a, input logic [7:0] l, input bit p, input int abort_at);
        do_cmd(C_WR, a, l, p);
        tick;
        for (int k = 0; k <= int'(l); k++) begin
            wdata = wbuf[k];
            dqm = mbuf[k];
            if (k == abort_at) rst = 1;
            tick;
            if (k == abort_at) begin
                rst = 0;
                dqm = 0;
                check("abort_data", rdata, 0);
                check("abort_err", perr, 0);
                m_open = 0;
                m_err = 0;
                m_known = 0;
                wait_init();
                return;
            end
            begin
                int i = idx(a[20:19], m_row, 8'(int'(a[7:0]) + k));
                for (int b = 0; b < 4; b++)
                    if (!mbuf[k][b]) begin
                        m_mem[i][b*8 +: 8] = wbuf[k][b*8 +: 8];
                        m_vb[i][b] = 1;
                    end
            end
        end
        dqm = 0;
    endtask

    task automatic read_burst(input logic [20:0] a, input logic [7:0] l, input bit p);
        int i = 0;
        bit last_ok = 0;
        do_cmd(C_RD, a, l, p);
        repeat (3) tick;
        for (int k = 0; k <= int'(l); k++) begin
            if (k > 0) tick;
            i = idx(a[20:19], m_row, 8'(int'(a[7:0]) + k));
            last_ok = m_known && m_vb[i] == 4'hF;
            if (last_ok) check($sformatf("rd_word[%0d]", k), rdata, m_mem[i]);
        end
        tick;
        if (last_ok) check("rd_hold", rdata, m_mem[i]);
    endtask

    initial begin
        int n;
        bit saw;
        vecs[0] = '{8'h20, 32'h00000000, 32'hAABBCCDD, 4'b0101, 32'hAA00CC00};
        vecs[1] = '{8'h21, 32'hDEADBEEF, 32'h12345678, 4'b1111, 32'hDEADBEEF};
        vecs[2] = '{8'h22, 32'hDEADBEEF, 32'h12345678, 4'b0000, 32'h12345678};
        vecs[3] = '{8'h23, 32'hFFFFFFFF, 32'h12345678, 4'b1010, 32'hFF34FF78};
        vecs[4] = '{8'h24, 32'h11223344, 32'hCAFEF00D, 4'b1000, 32'h11FEF00D};
        vecs[5] = '{8'h25, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 32'h000000FF};

        // reset values and init timing with cmd_en misuse during INIT
        tick;
        tick;
        check_reset_vals();
        rst = 0;
        cmd = C_NOP;
        cmd_en = 1;
        n = 0;
        saw = 0;
        while (!init_done && n < 40) begin
            tick;
            n++;
            if (ack) saw = 1;
            if (n == 3) cmd_en = 0;
        end
        check("init_cycles_first", n, 16);
        check("init_no_ack", saw, 0);
        check("init_misuse_err", perr, 1);
        do_reset();

        // activate row 1, four-word write then read back
        simple(C_ACT, 21'h000100);
        for (int k = 0; k < 4; k++) begin
            wbuf[k] = 32'h11111111 * (k + 1);
            mbuf[k] = 0;
        end
        write_burst(21'h000000, 3, 0, -1);
        read_burst(21'h000000, 3, 0);
        check("err_clean", perr, 0);

        // byte-mask table
        for (int v = 0; v < 6; v++) begin
            wbuf[0] = vecs[v].prev;
            mbuf[0] = 0;
            write_burst({2'b00, 11'h001, vecs[v].col}, 0, 0, -1);
            wbuf[0] = vecs[v].data;
            mbuf[0] = vecs[v].dqm;
            write_burst({2'b00, 11'h001, vecs[v].col}, 0, 0, -1);
            read_burst({2'b00, 11'h001, vecs[v].col}, 0, 0);
            check($sformatf("vec%0d", v), rdata, vecs[v].exp);
        end

        // column wrap within the row
        wbuf[0] = 32'hA0A0A0A0;
        wbuf[1] = 32'hA1A1A1A1;
        wbuf[2] = 32'hA2A2A2A2;
        mbuf[0] = 0;
        mbuf[1] = 0;
        mbuf[2] = 0;
        write_burst(21'h0000FE, 2, 0, -1);
        read_burst(21'h000000, 0, 0);
        check("wrap_col00", rdata, 32'hA2A2A2A2);
        read_burst(21'h0000FF, 0, 0);
        check("wrap_colFF", rdata, 32'hA1A1A1A1);
        read_burst(21'h0000FE, 2, 0);

        // 256-word burst covers the row once
        for (int k = 0; k < 256; k++) begin
            wbuf[k] = $urandom;
            mbuf[k] = 0;
        end
        write_burst(21'h000010, 255, 0, -1);
        read_burst(21'h000090, 255, 0);
        read_burst(21'h00000F, 0, 0);
        check("full_row_last", rdata, wbuf[255]);
        check("err_still_clean", perr, 0);

        // refresh busy window: cmd_en ignored, accepted once IDLE again
        do_cmd(C_REF, '0, 0, 0);
        tick;
        cmd = C_NOP;
        cmd_en = 1;
        saw = 0;
        repeat (5) begin
            tick;
            if (ack) saw = 1;
        end
        cmd_en = 0;
        m_err = 1;
        check("ref_no_ack", saw, 0);
        tick;
        tick;
        cmd_en = 1;
        tick;
        check("ref_last_busy", ack, 0);
        tick;
        cmd_en = 0;
        check("ref_ack_after", ack, 1);
        tick;
        check("ref_err", perr, 1);

        // auto-precharge closes the row at burst end
        do_reset();
        simple(C_ACT, 21'h000200);
        wbuf[0] = 32'h01020304;
        wbuf[1] = 32'h05060708;
        mbuf[0] = 0;
        mbuf[1] = 0;
        write_burst(21'h000005, 1, 1, -1);
        check("pc_no_err", perr, 0);
        read_burst(21'h000005, 1, 0);
        check("pc_closed_err", perr, 1);

        // wrong bank still executes with the latched row
        do_reset();
        simple(C_ACT, {2'b01, 11'h002, 8'h00});
        wbuf[0] = 32'h5A5A1234;
        mbuf[0] = 0;
        write_burst({2'b10, 11'h7FF, 8'h09}, 0, 0, -1);
        check("bank_err", perr, 1);
        read_burst({2'b01, 11'h000, 8'h09}, 0, 0);
        check("bank_data", rdata, 32'h5A5A1234);

        // read without activate: acked, error sticky
        do_reset();
        read_burst(21'h000000, 0, 0);
        check("noact_err", perr, 1);
        simple(C_NOP, '0);
        simple(C_LMR, '0);
        check("noact_sticky", perr, 1);

        // refresh closes an open row
        do_reset();
        simple(C_ACT, 21'h000100);
        refresh();
        check("ref_pre_err", perr, 0);
        read_burst(21'h000000, 0, 0);
        check("ref_closed_err", perr, 1);

        // reset in the middle of a write burst
        do_reset();
        simple(C_ACT, 21'h000300);
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = 32'h0D000000 + k;
            mbuf[k] = 0;
        end
        write_burst(21'h000040, 7, 0, -1);
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hE0000000 + k;
        write_burst(21'h000040, 7, 0, 3);
        simple(C_ACT, 21'h000300);
        read_burst(21'h000043, 0, 0);
        check("abort_word3_old", rdata, 32'h0D000003);
        read_burst(21'h000040, 7, 0);

        // random traffic against the model
        do_reset();
        simple(C_ACT, {2'($urandom), 11'($urandom_range(0, 3)), 8'h00});
        for (int t = 0; t < 40; t++) begin
            int op = $urandom_range(0, 9);
            logic [20:0] a = {2'($urandom_range(0, 3)), 11'($urandom_range(0, 3)), 8'($urandom_range(0, 31))};
            logic [7:0] l = 8'($urandom_range(0, 15));
            bit p = $urandom_range(0, 3) == 0;
            if (op < 2) simple(C_ACT, a);
            else if (op < 5) begin
                for (int k = 0; k <= int'(l); k++) begin
                    wbuf[k] = $urandom;
                    mbuf[k] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                end
                write_burst(a, l, p, -1);
            end
            else if (op < 8) read_burst(a, l, p);
            else if (op == 8) simple(C_PRE, a);
            else refresh();
            check("rand_err", perr, m_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
